// File: rtl/receive_engine_pkg.sv
// Shared UART receive definitions: FSM states, bit-time width, frame decode.
package receive_engine_pkg;

  localparam int RX_KW_DEFAULT = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_char_t;

  // Bits sampled after the start bit, stop included: 8..10.
  function automatic logic [3:0] frame_bits(input logic eight, input logic pen);
    return 4'd8 + {3'd0, eight} + {3'd0, pen};
  endfunction

  // Bits enter the shift register at the top, so a short frame sits in the
  // upper n bits; shifting down by 10-n puts the first data bit at bit 0.
  function automatic rx_char_t decode_frame(input logic [9:0] sr, input logic eight,
                                            input logic pen, input logic ohel);
    logic [3:0] n;
    logic [9:0] a;
    logic       par;
    rx_char_t   r;
    n      = frame_bits(eight, pen);
    a      = sr >> (4'd10 - n);
    r.data = eight ? a[7:0] : {1'b0, a[6:0]};
    par    = eight ? a[8] : a[7];
    r.perr = pen & (par != (^r.data ^ ohel));
    r.ferr = ~a[n - 4'd1];
    return r;
  endfunction

endpackage

// File: rtl/receive_engine_bit_timer.sv
// Bit-time counter with half-period and full-period terminal flags against k.
module uart_bit_timer #(
  parameter int KW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [KW-1:0] k_i,
  output logic          half_o,
  output logic          full_o
);

  logic [KW-1:0] cnt_q;

  // Clear wins over enable so the FSM can restart a bit period on the terminal cycle.
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i)    cnt_q <= cnt_q + 1'b1;
  end

  assign half_o = (cnt_q == (k_i >> 1));
  assign full_o = (cnt_q == k_i);

endmodule

// File: rtl/receive_engine.sv
// UART receive engine: synchronise rx, sample mid-bit, deliver char + status.
module receive_engine
  import receive_engine_pkg::*;
#(
  parameter int KW = RX_KW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic          eight,
  input  logic          pen,
  input  logic          ohel,
  input  logic [KW-1:0] k,
  input  logic          read,
  output logic [7:0]    rx_data,
  output logic          rxrdy,
  output logic          perr,
  output logic          ferr,
  output logic          ovf
);

  rx_state_e  state_q, state_d;
  logic       rx_meta_q, rx_s_q;
  logic [3:0] bit_cnt_q;
  logic [9:0] sr_q;
  logic [7:0] rx_data_q;
  logic       rxrdy_q, perr_q, ferr_q, ovf_q;

  logic       tmr_clr, tmr_en, tmr_half, tmr_full;
  logic       shift, bit_clr, done;
  logic [3:0] n;
  rx_char_t   rxc;

  assign n   = frame_bits(eight, pen);
  assign rxc = decode_frame(sr_q, eight, pen, ohel);

  uart_bit_timer #(.KW(KW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .k_i    (k),
    .half_o (tmr_half),
    .full_o (tmr_full)
  );

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath strobes; the timer restarts at every sample point.
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    shift   = 1'b0;
    bit_clr = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (!rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        tmr_en = 1'b1;
        if (tmr_half) begin
          tmr_clr = 1'b1;
          bit_clr = 1'b1;
          // A line back high at mid-start is a glitch; drop it silently.
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        tmr_en = 1'b1;
        if (tmr_full) begin
          tmr_clr = 1'b1;
          shift   = 1'b1;
          if (bit_cnt_q == n - 4'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift register and sampled-bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      if (bit_clr)    bit_cnt_q <= '0;
      else if (shift) bit_cnt_q <= bit_cnt_q + 4'd1;
      if (shift)      sr_q      <= {rx_s_q, sr_q[9:1]};
    end
  end

  // Status registers: a completing frame beats a coincident read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q <= '0;
      rxrdy_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (done) begin
      rx_data_q <= rxc.data;
      perr_q    <= rxc.perr;
      ferr_q    <= rxc.ferr;
      rxrdy_q   <= 1'b1;
      ovf_q     <= ~read & (ovf_q | rxrdy_q);
    end else if (read && rxrdy_q) begin
      rxrdy_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end
  end

  assign rx_data = rx_data_q;
  assign rxrdy   = rxrdy_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;
  assign ovf     = ovf_q;

endmodule
